// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for a 1W/1R byte-masked memory, with a fixed
// one-cycle read response path. Optional grant/collision counters: MEM_ARBITER_STATS_EN.
module mem_arbiter #(
  parameter int MEM_WIDTH_BYTES = 8,
  parameter int MEM_DEPTH       = 1024,
  parameter int SHOWAHEAD       = 0,
  localparam int AW = $clog2(MEM_DEPTH),
  localparam int DW = MEM_WIDTH_BYTES * 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req0_valid_in,
  output logic                       req0_ready_out,
  input  logic                       req0_write_in,
  input  logic [AW-1:0]              req0_addr_in,
  input  logic [DW-1:0]              req0_data_in,
  input  logic [MEM_WIDTH_BYTES-1:0] req0_mask_in,
  input  logic                       req1_valid_in,
  output logic                       req1_ready_out,
  input  logic                       req1_write_in,
  input  logic [AW-1:0]              req1_addr_in,
  input  logic [DW-1:0]              req1_data_in,
  input  logic [MEM_WIDTH_BYTES-1:0] req1_mask_in,
  output logic                       resp0_valid_out,
  output logic [DW-1:0]              resp0_data_out,
  output logic                       resp1_valid_out,
  output logic [DW-1:0]              resp1_data_out,
  output logic [AW-1:0]              mem_write_addr_out,
  output logic                       mem_write_out,
  output logic [DW-1:0]              mem_write_data_out,
  output logic [MEM_WIDTH_BYTES-1:0] mem_write_mask_out,
  output logic [AW-1:0]              mem_read_addr_out,
  output logic                       mem_read_out,
  input  logic [DW-1:0]              mem_read_data_in,
`ifdef MEM_ARBITER_STATS_EN
  output logic [31:0]                stat_wr_grants_out,
  output logic [31:0]                stat_rd_grants_out,
  output logic [31:0]                stat_collisions_out,
`endif
  input  logic                       debugen_in
);

  logic          wr_prio_q, wr_prio_d, rd_prio_q, rd_prio_d;
  logic          rsp0_q, rsp0_d, rsp1_q, rsp1_d;
  logic [DW-1:0] rdata_q, rdata_d, resp_src;
  logic          wr_c0, wr_c1, rd_c0, rd_c1;
  logic          wr_g0, wr_g1, rd_w0, rd_w1, rd_g0, rd_g1, collision;
  logic [AW-1:0] rd_w_addr;

  always_comb begin
    wr_c0 = req0_valid_in & req0_write_in;
    wr_c1 = req1_valid_in & req1_write_in;
    rd_c0 = req0_valid_in & ~req0_write_in;
    rd_c1 = req1_valid_in & ~req1_write_in;
    // Grants are gated by reset so ready/strobes drop the instant reset asserts.
    wr_g0 = ~reset & wr_c0 & (~wr_c1 | ~wr_prio_q);
    wr_g1 = ~reset & wr_c1 & (~wr_c0 | wr_prio_q);
    rd_w0 = ~reset & rd_c0 & (~rd_c1 | ~rd_prio_q);
    rd_w1 = ~reset & rd_c1 & (~rd_c0 | rd_prio_q);

    mem_write_out      = wr_g0 | wr_g1;
    mem_write_addr_out = '0;
    mem_write_data_out = '0;
    mem_write_mask_out = '0;
    if (wr_g0) begin
      mem_write_addr_out = req0_addr_in;
      mem_write_data_out = req0_data_in;
      mem_write_mask_out = req0_mask_in;
    end else if (wr_g1) begin
      mem_write_addr_out = req1_addr_in;
      mem_write_data_out = req1_data_in;
      mem_write_mask_out = req1_mask_in;
    end

    rd_w_addr = '0;
    if (rd_w0)      rd_w_addr = req0_addr_in;
    else if (rd_w1) rd_w_addr = req1_addr_in;

    // Same-address read loses to the write and retries without consuming its turn.
    collision = mem_write_out & (rd_w0 | rd_w1) & (rd_w_addr == mem_write_addr_out);
    rd_g0 = rd_w0 & ~collision;
    rd_g1 = rd_w1 & ~collision;

    mem_read_out      = rd_g0 | rd_g1;
    mem_read_addr_out = mem_read_out ? rd_w_addr : '0;

    req0_ready_out = wr_g0 | rd_g0;
    req1_ready_out = wr_g1 | rd_g1;

    wr_prio_d = wr_prio_q;
    if (wr_g0)      wr_prio_d = 1'b1;
    else if (wr_g1) wr_prio_d = 1'b0;
    rd_prio_d = rd_prio_q;
    if (rd_g0)      rd_prio_d = 1'b1;
    else if (rd_g1) rd_prio_d = 1'b0;

    rsp0_d  = rd_g0;
    rsp1_d  = rd_g1;
    rdata_d = mem_read_out ? mem_read_data_in : rdata_q;

    resp_src        = (SHOWAHEAD != 0) ? rdata_q : mem_read_data_in;
    resp0_valid_out = rsp0_q;
    resp1_valid_out = rsp1_q;
    resp0_data_out  = rsp0_q ? resp_src : '0;
    resp1_data_out  = rsp1_q ? resp_src : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_prio_q <= 1'b0;
      rd_prio_q <= 1'b0;
      rsp0_q    <= 1'b0;
      rsp1_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      wr_prio_q <= wr_prio_d;
      rd_prio_q <= rd_prio_d;
      rsp0_q    <= rsp0_d;
      rsp1_q    <= rsp1_d;
      rdata_q   <= rdata_d;
    end
  end

`ifdef MEM_ARBITER_STATS_EN
  logic [31:0] st_wr_q, st_wr_d, st_rd_q, st_rd_d, st_col_q, st_col_d;

  always_comb begin
    st_wr_d  = st_wr_q;
    st_rd_d  = st_rd_q;
    st_col_d = st_col_q;
    if (mem_write_out && st_wr_q != '1) st_wr_d  = st_wr_q + 32'd1;
    if (mem_read_out  && st_rd_q != '1) st_rd_d  = st_rd_q + 32'd1;
    if (collision && st_col_q != '1)    st_col_d = st_col_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_wr_q  <= '0;
      st_rd_q  <= '0;
      st_col_q <= '0;
    end else begin
      st_wr_q  <= st_wr_d;
      st_rd_q  <= st_rd_d;
      st_col_q <= st_col_d;
    end
  end

  assign stat_wr_grants_out  = st_wr_q;
  assign stat_rd_grants_out  = st_rd_q;
  assign stat_collisions_out = st_col_q;
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (debugen_in && !reset)
      $write("%0t mem_arbiter: wr_g=%b%b rd_g=%b%b coll=%b resp=%b%b\n",
             $time, wr_g1, wr_g0, rd_g1, rd_g0, collision, rsp1_q, rsp0_q);
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance per SHOWAHEAD mode on shared stimulus,
// each backed by a small byte-masked memory model.
module tb_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          v0, w0, v1, w1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;
  logic [7:0]    m0, m1;

  logic          a_r0, a_r1, a_rv0, a_rv1, a_mw, a_mr;
  logic [DW-1:0] a_rd0, a_rd1, a_wd, a_rdat;
  logic [AW-1:0] a_wa, a_ra;
  logic [7:0]    a_wm;
  logic          b_r0, b_r1, b_rv0, b_rv1, b_mw, b_mr;
  logic [DW-1:0] b_rd0, b_rd1, b_wd, b_rdat;
  logic [AW-1:0] b_wa, b_ra;
  logic [7:0]    b_wm;
`ifdef MEM_ARBITER_STATS_EN
  logic [31:0] a_swr, a_srd, a_scol, b_swr, b_srd, b_scol;
`endif

  mem_arbiter #(.MEM_WIDTH_BYTES(8), .MEM_DEPTH(1024), .SHOWAHEAD(0)) dut_a (
    .clk(clk), .reset(reset),
    .req0_valid_in(v0), .req0_ready_out(a_r0), .req0_write_in(w0), .req0_addr_in(a0),
    .req0_data_in(d0), .req0_mask_in(m0),
    .req1_valid_in(v1), .req1_ready_out(a_r1), .req1_write_in(w1), .req1_addr_in(a1),
    .req1_data_in(d1), .req1_mask_in(m1),
    .resp0_valid_out(a_rv0), .resp0_data_out(a_rd0),
    .resp1_valid_out(a_rv1), .resp1_data_out(a_rd1),
    .mem_write_addr_out(a_wa), .mem_write_out(a_mw), .mem_write_data_out(a_wd),
    .mem_write_mask_out(a_wm), .mem_read_addr_out(a_ra), .mem_read_out(a_mr),
    .mem_read_data_in(a_rdat),
`ifdef MEM_ARBITER_STATS_EN
    .stat_wr_grants_out(a_swr), .stat_rd_grants_out(a_srd), .stat_collisions_out(a_scol),
`endif
    .debugen_in(1'b0)
  );

  mem_arbiter #(.MEM_WIDTH_BYTES(8), .MEM_DEPTH(1024), .SHOWAHEAD(1)) dut_b (
    .clk(clk), .reset(reset),
    .req0_valid_in(v0), .req0_ready_out(b_r0), .req0_write_in(w0), .req0_addr_in(a0),
    .req0_data_in(d0), .req0_mask_in(m0),
    .req1_valid_in(v1), .req1_ready_out(b_r1), .req1_write_in(w1), .req1_addr_in(a1),
    .req1_data_in(d1), .req1_mask_in(m1),
    .resp0_valid_out(b_rv0), .resp0_data_out(b_rd0),
    .resp1_valid_out(b_rv1), .resp1_data_out(b_rd1),
    .mem_write_addr_out(b_wa), .mem_write_out(b_mw), .mem_write_data_out(b_wd),
    .mem_write_mask_out(b_wm), .mem_read_addr_out(b_ra), .mem_read_out(b_mr),
    .mem_read_data_in(b_rdat),
`ifdef MEM_ARBITER_STATS_EN
    .stat_wr_grants_out(b_swr), .stat_rd_grants_out(b_srd), .stat_collisions_out(b_scol),
`endif
    .debugen_in(1'b0)
  );

  // Memory models: A has a registered read port, B a combinational one.
  logic [DW-1:0] mem_a [0:1023];
  logic [DW-1:0] mem_b [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
  end
  always @(posedge clk) begin
    if (a_mr) a_rdat <= mem_a[a_ra];
    if (a_mw) for (int b = 0; b < 8; b++) if (a_wm[b]) mem_a[a_wa][b*8 +: 8] = a_wd[b*8 +: 8];
    if (b_mw) for (int b = 0; b < 8; b++) if (b_wm[b]) mem_b[b_wa][b*8 +: 8] = b_wd[b*8 +: 8];
  end
  assign b_rdat = mem_b[b_ra];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic v0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0; logic [7:0] m0;
    logic v1, w1; logic [AW-1:0] a1; logic [DW-1:0] d1; logic [7:0] m1;
    logic r0, r1;
    logic rv0; logic [DW-1:0] rd0;
    logic rv1; logic [DW-1:0] rd1;
  } vec_t;

  function automatic vec_t mkv(
      input logic iv0, input logic iw0, input logic [AW-1:0] ia0, input logic [DW-1:0] id0, input logic [7:0] im0,
      input logic iv1, input logic iw1, input logic [AW-1:0] ia1, input logic [DW-1:0] id1, input logic [7:0] im1,
      input logic er0, input logic er1,
      input logic erv0, input logic [DW-1:0] erd0, input logic erv1, input logic [DW-1:0] erd1);
    vec_t t;
    t.v0 = iv0; t.w0 = iw0; t.a0 = ia0; t.d0 = id0; t.m0 = im0;
    t.v1 = iv1; t.w1 = iw1; t.a1 = ia1; t.d1 = id1; t.m1 = im1;
    t.r0 = er0; t.r1 = er1;
    t.rv0 = erv0; t.rd0 = erd0; t.rv1 = erv1; t.rd1 = erd1;
    return t;
  endfunction

  localparam logic [DW-1:0] DA = 64'h1122334455667788;
  localparam logic [DW-1:0] DB = 64'hA5A55A5A0F0FF0F0;
  localparam logic [DW-1:0] DC = 64'hCAFEBABEDEADBEEF;
  localparam logic [DW-1:0] DX = 64'h0123456789ABCDEF;
  localparam logic [DW-1:0] DF = 64'hFFFFFFFFFFFFFFFF;

  vec_t vecs [0:19];

  task automatic idle();
    v0 = 0; w0 = 0; a0 = '0; d0 = '0; m0 = '0;
    v1 = 0; w1 = 0; a1 = '0; d1 = '0; m1 = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t t;
    logic [DW-1:0] ewa, ewd;
    logic [7:0]    ewm;
    logic [AW-1:0] era;
    logic          emw, emr;
    int n;

    n = 0;
    vecs[n++] = mkv(1,1,5,DA,8'hFF,   0,0,0,0,0,           1,0, 0,0,       0,0);
    vecs[n++] = mkv(1,0,5,0,0,        0,0,0,0,0,           1,0, 0,0,       0,0);
    vecs[n++] = mkv(0,0,0,0,0,        1,1,20,DB,8'hFF,     0,1, 1,DA,      0,0);
    for (int i = 0; i < 6; i++)
      vecs[n++] = mkv(1,1,10,64'h10,8'hFF, 1,1,11,64'h11,8'hFF, (i % 2) == 0, (i % 2) == 1, 0,0, 0,0);
    vecs[n++] = mkv(1,0,10,0,0,       1,0,11,0,0,          0,1, 0,0,       0,0);
    vecs[n++] = mkv(1,0,10,0,0,       1,0,11,0,0,          1,0, 0,0,       1,64'h11);
    vecs[n++] = mkv(0,0,0,0,0,        0,0,0,0,0,           0,0, 1,64'h10,  0,0);
    vecs[n++] = mkv(1,1,30,DX,8'hFF,  1,0,20,0,0,          1,1, 0,0,       0,0);
    vecs[n++] = mkv(0,0,0,0,0,        0,0,0,0,0,           0,0, 0,0,       1,DB);
    vecs[n++] = mkv(1,1,9,DC,8'hFF,   1,0,9,0,0,           1,0, 0,0,       0,0);
    vecs[n++] = mkv(0,0,0,0,0,        1,0,9,0,0,           0,1, 0,0,       0,0);
    vecs[n++] = mkv(0,0,0,0,0,        0,0,0,0,0,           0,0, 0,0,       1,DC);
    vecs[n++] = mkv(0,0,0,0,0,        1,1,40,DF,8'h0F,     0,1, 0,0,       0,0);
    vecs[n++] = mkv(1,0,40,0,0,       0,0,0,0,0,           1,0, 0,0,       0,0);
    vecs[n++] = mkv(0,0,0,0,0,        0,0,0,0,0,           0,0, 1,64'h00000000FFFFFFFF, 0,0);

    // Reset with a live write request: nothing may be granted.
    reset = 1'b1;
    idle();
    v0 = 1; w0 = 1; a0 = 3; d0 = DX; m0 = 8'hFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst ready0_a", a_r0, 0);
    chk("rst mem_write_a", a_mw, 0);
    chk("rst mem_write_addr_a", a_wa, 0);
    chk("rst ready0_b", b_r0, 0);
    chk("rst resp0_valid_a", a_rv0, 0);
    chk("rst resp0_data_b", b_rd0, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < n; i++) begin
      t = vecs[i];
      v0 = t.v0; w0 = t.w0; a0 = t.a0; d0 = t.d0; m0 = t.m0;
      v1 = t.v1; w1 = t.w1; a1 = t.a1; d1 = t.d1; m1 = t.m1;
      emw = (t.r0 & t.w0) | (t.r1 & t.w1);
      emr = (t.r0 & ~t.w0) | (t.r1 & ~t.w1);
      ewa = '0; ewd = '0; ewm = '0; era = '0;
      if (t.r0 & t.w0)  begin ewa = DW'(t.a0); ewd = t.d0; ewm = t.m0; end
      if (t.r1 & t.w1)  begin ewa = DW'(t.a1); ewd = t.d1; ewm = t.m1; end
      if (t.r0 & ~t.w0) era = t.a0;
      if (t.r1 & ~t.w1) era = t.a1;
      @(negedge clk);
      chk($sformatf("v%0d ready0_a", i), a_r0, t.r0);
      chk($sformatf("v%0d ready1_a", i), a_r1, t.r1);
      chk($sformatf("v%0d ready0_b", i), b_r0, t.r0);
      chk($sformatf("v%0d ready1_b", i), b_r1, t.r1);
      chk($sformatf("v%0d mem_write", i), a_mw, emw);
      chk($sformatf("v%0d mem_write_addr", i), a_wa, ewa);
      chk($sformatf("v%0d mem_write_data", i), a_wd, ewd);
      chk($sformatf("v%0d mem_write_mask", i), a_wm, ewm);
      chk($sformatf("v%0d mem_read", i), a_mr, emr);
      chk($sformatf("v%0d mem_read_addr", i), a_ra, era);
      chk($sformatf("v%0d mem_read_b", i), b_mr, emr);
      chk($sformatf("v%0d resp0_valid_a", i), a_rv0, t.rv0);
      chk($sformatf("v%0d resp0_data_a", i), a_rd0, t.rd0);
      chk($sformatf("v%0d resp1_valid_a", i), a_rv1, t.rv1);
      chk($sformatf("v%0d resp1_data_a", i), a_rd1, t.rd1);
      chk($sformatf("v%0d resp0_valid_b", i), b_rv0, t.rv0);
      chk($sformatf("v%0d resp0_data_b", i), b_rd0, t.rd0);
      chk($sformatf("v%0d resp1_valid_b", i), b_rv1, t.rv1);
      chk($sformatf("v%0d resp1_data_b", i), b_rd1, t.rd1);
      @(posedge clk); #1;
    end

`ifdef MEM_ARBITER_STATS_EN
    chk("stat wr_grants_a", a_swr, 11);
    chk("stat rd_grants_a", a_srd, 6);
    chk("stat collisions_a", a_scol, 1);
    chk("stat wr_grants_b", b_swr, 11);
`endif

    // Read granted, then reset asserted in the response cycle: response must vanish at once.
    idle();
    v0 = 1; w0 = 0; a0 = 5;
    @(negedge clk);
    chk("mid ready0_a", a_r0, 1);
    chk("mid mem_read_addr", a_ra, 5);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("mid resp0_valid_a", a_rv0, 0);
    chk("mid resp0_valid_b", b_rv0, 0);
    chk("mid resp0_data_a", a_rd0, 0);
    chk("mid resp0_data_b", b_rd0, 0);
    chk("mid ready0_a", a_r0, 0);
    chk("mid mem_read_a", a_mr, 0);
    chk("mid mem_read_addr_a", a_ra, 0);
    chk("mid mem_read_b", b_mr, 0);
`ifdef MEM_ARBITER_STATS_EN
    chk("mid stat_wr_a", a_swr, 0);
    chk("mid stat_rd_a", a_srd, 0);
    chk("mid stat_col_a", a_scol, 0);
`endif
    @(posedge clk); #1;
    idle();
    reset = 1'b0;
    @(negedge clk);
    chk("post resp0_valid_a", a_rv0, 0);
    chk("post resp0_valid_b", b_rv0, 0);
    // Priorities are back to requester 0 after reset.
    v0 = 1; w0 = 1; a0 = 7; d0 = DA; m0 = 8'hFF;
    v1 = 1; w1 = 1; a1 = 8; d1 = DB; m1 = 8'hFF;
    #1;
    chk("post wr_prio ready0", a_r0, 1);
    chk("post wr_prio ready1", a_r1, 0);
    @(posedge clk); #1;
    idle();
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter in front of one `Memory` instance (one write port, one read port, byte-masked writes). It sits between the fetch/load-store side and the shared RAM. It arbitrates the write port and the read port independently with round-robin priority. It also resolves same-address read/write collisions and returns read data on a fixed one-cycle response path that does not depend on the memory's `SHOWAHEAD` setting.

## Interface
- `MEM_WIDTH_BYTES`, 8, data word width in bytes; must equal the attached `Memory`.
- `MEM_DEPTH`, 1024, words in the memory; address width is `AW = $clog2(MEM_DEPTH)`.
- `SHOWAHEAD`, 0, must equal the attached `Memory`: 1 = combinational read, 0 = registered read.

Ports:
- `clk` in 1: the single clock; all logic is on posedge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `reqN_valid_in` in 1 (N = 0, 1): request present.
- `reqN_ready_out` out 1: request accepted this cycle.
- `reqN_write_in` in 1: 1 = write, 0 = read.
- `reqN_addr_in` in AW: word address.
- `reqN_data_in` in MEM_WIDTH_BYTES*8: write data.
- `reqN_mask_in` in MEM_WIDTH_BYTES: byte enables.
- `respN_valid_out` out 1: read data valid.
- `respN_data_out` out MEM_WIDTH_BYTES*8: read data.
- `mem_write_addr_out`, `mem_write_out`, `mem_write_data_out`, `mem_write_mask_out` out: drive the memory write port.
- `mem_read_addr_out`, `mem_read_out` out: drive the memory read port.
- `mem_read_data_in` in MEM_WIDTH_BYTES*8: memory read data.
- `debugen_in` in 1: per-cycle `$write` trace of grants and responses.

## Operation
- A request transfers when `valid & ready` are both high in the same cycle.
- `ready` is combinational from the current `valid`/`write`/`addr` inputs and the priority registers.
- A requester holds its request stable until it is accepted.
- **Write arbitration:**
  - Candidates are requesters with `valid & write`.
  - If only one candidate, it wins.
  - If both, the requester indicated by `wr_prio` wins.
  - After any write grant, `wr_prio` points to the other requester.
- **Read arbitration:** same scheme with its own `rd_prio` register, among requesters with `valid & !write`.
- A write and a read from different requesters can both be granted in the same cycle.
- **Collision rule:** if the granted read and the granted write target the same address in the same cycle:
  - the write proceeds;
  - the read is not granted (`ready` low) and retries next cycle;
  - `rd_prio` does not change.
- **Memory port outputs:**
  - Granted write: drive `mem_write_out`=1 with the winner's addr/data/mask; otherwise `mem_write_out`=0.
  - Granted read: drive `mem_read_out`=1 and the winner's addr; otherwise `mem_read_out`=0.
  - Unused address and data outputs are 0.
- **Read response:**
  - `respN_valid_out` pulses high exactly one cycle after requester N's read grant.
  - `SHOWAHEAD`=0: `respN_data_out` = `mem_read_data_in` in the response cycle.
  - `SHOWAHEAD`=1: the arbiter registers `mem_read_data_in` in the grant cycle and presents it in the response cycle.
  - In both modes `respN_data_out` is 0 whenever `respN_valid_out` is 0.
- Responses cannot be back-pressured. Each requester sustains one read per cycle.
- A single requester's write data is never split across cycles. Mask bits of 0 leave those bytes unchanged.

## Timing
- **Reset values:**
  - all `ready`, `resp*_valid_out`, and `mem_*_out` strobes = 0;
  - all data and address outputs = 0;
  - `wr_prio` = `rd_prio` = 0 (requester 0 first).
  - Asynchronous assertion forces these values immediately.
  - Deassertion takes effect at the next posedge.
- **Reset mid-operation:** an in-flight response (granted the cycle before reset) is dropped, with no `resp` pulse. A write granted in the same cycle reset asserts is not guaranteed to commit.
- **Latency:** request to memory strobe is 0 cycles (combinational). Read grant to `resp_valid` is exactly 1 cycle.
- **Throughput:** up to one write plus one read per cycle. Each requester gets at least one grant every 2 cycles of its port under continuous contention.
- **Collision stall:** exactly 1 extra cycle per collision, unless the write requester keeps writing the same address (by design, writes dominate).
- Address compare is full-width AW equality. No wrap-around arithmetic exists in the block.

## Configuration
- `MEM_ARBITER_STATS_EN`:
  - **Defined:** adds `stat_wr_grants_out[31:0]`, `stat_rd_grants_out[31:0]`, and `stat_collisions_out[31:0]`.
    - These are saturating counters (hold at 0xFFFFFFFF) of write grants, read grants, and collision stalls.
    - They are cleared by `reset`.
  - **Undefined:** the ports and counters are absent. Arbitration behaviour is identical.

## Test plan
- Reset, then req0 writes addr 5 data 0x1122334455667788 mask 0xFF; next cycle req0 reads addr 5 -> `resp0_valid_out` one cycle after the read grant, data 0x1122334455667788. Run with `SHOWAHEAD`=0 and 1.
- Both requesters write every cycle for 6 cycles -> grants alternate 0,1,0,1,0,1; each `ready` high exactly 3 times.
- req0 writes addr 9 while req1 reads addr 9 in the same cycle -> write granted, `req1_ready_out`=0; read granted next cycle and returns the new data.
- Write mask 0x0F with data 0xFFFFFFFFFFFFFFFF over stored 0 -> readback 0x00000000FFFFFFFF.
- Assert `reset` in the cycle after a read grant -> no `resp_valid` pulse; all outputs 0 immediately. With `MEM_ARBITER_STATS_EN`, the counters read 0.
